// File: rtl/bitfill_sequencer.sv
// Triangular (i,j) sweep that writes serial bits into a ROWS x DATA_W register
// array, skipping bit positions beyond the row width; combinational row read port.
module bitfill_sequencer #(
    parameter int ROWS     = 4,
    parameter int DATA_W   = 8,
    parameter int I_FIRST  = 1,
    parameter int I_LAST   = 2,
    parameter int J_OFFSET = 3,
    parameter int J_LAST   = 15,
    parameter int ROW_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic              din,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ROW_W-1:0]  wr_row,
    output logic [3:0]        wr_bit,
    output logic [7:0]        skip_cnt,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [DATA_W-1:0] rd_data
);

    localparam int IDX_W = 8;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [IDX_W-1:0] I_FIRST_V  = IDX_W'(I_FIRST);
    localparam logic [IDX_W-1:0] I_LAST_V   = IDX_W'(I_LAST);
    localparam logic [IDX_W-1:0] J_OFFSET_V = IDX_W'(J_OFFSET);
    localparam logic [IDX_W-1:0] J_LAST_V   = IDX_W'(J_LAST);
    localparam logic [IDX_W-1:0] DATA_W_V   = IDX_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] i_q, i_nx;
    logic [IDX_W-1:0] j_q, j_nx;
    logic [7:0]       skip_q, skip_nx;
    logic             in_range;
    logic             in_data;

    logic [DATA_W-1:0] mem [ROWS];

    assign in_range = (j_q <= J_LAST_V);
    assign in_data  = (j_q < DATA_W_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            i_q    <= '0;
            j_q    <= '0;
            skip_q <= '0;
        end else begin
            state  <= state_nx;
            i_q    <= i_nx;
            j_q    <= j_nx;
            skip_q <= skip_nx;
        end
    end

    always_comb begin
        state_nx = state;
        i_nx     = i_q;
        j_nx     = j_q;
        skip_nx  = skip_q;
        wr_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    i_nx     = I_FIRST_V;
                    j_nx     = I_FIRST_V + J_OFFSET_V;
                    skip_nx  = '0;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    // Out-of-range j is a bubble: neither a write nor a skip
                    if (in_range && in_data) begin
                        wr_en = 1'b1;
                    end else if (in_range && (skip_q != 8'hFF)) begin
                        skip_nx = skip_q + 8'd1;
                    end
                    if (j_q >= J_LAST_V) begin
                        if (i_q == I_LAST_V) begin
                            state_nx = S_DONE;
                        end else begin
                            i_nx = i_q + 1'b1;
                            j_nx = i_q + 1'b1 + J_OFFSET_V;
                        end
                    end else begin
                        j_nx = j_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[i_q[ROW_W-1:0]][j_q[BIT_W-1:0]] <= din;
        end
    end

    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign wr_row   = i_q[ROW_W-1:0];
    assign wr_bit   = j_q[3:0];
    assign skip_cnt = skip_q;
    assign rd_data  = mem[rd_row];

endmodule
